// File: rtl/dsc_ctrl_mm.sv
// dsc_ctrl_mm: Avalon-MM run controller for a bank of NUM_ENG downscale engines.
// Define DSC_CTRL_IRQ_EN to build the done/error interrupt and its IRQ_EN register.
`timescale 1ns/1ps
module dsc_ctrl_mm #(
    parameter int NUM_ENG    = 2,
    parameter int IMG_ADDR_W = 18,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [3:0]            avs_address,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    output logic [NUM_ENG-1:0]    eng_start,
    output logic [NUM_ENG-1:0]    eng_cfg_we,
    output logic [IMG_ADDR_W-1:0] eng_cfg_addr,
    output logic [7:0]            eng_cfg_data,
    output logic [15:0]           x_ratio,
    output logic [15:0]           y_ratio,
    input  logic [NUM_ENG-1:0]    eng_done,
    input  logic [8*NUM_ENG-1:0]  eng_dbg,
    output logic                  irq
);
    localparam int SEL_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    localparam logic [3:0] A_CTRL  = 4'd0;
    localparam logic [3:0] A_SEL   = 4'd1;
    localparam logic [3:0] A_XRAT  = 4'd2;
    localparam logic [3:0] A_YRAT  = 4'd3;
    localparam logic [3:0] A_IADDR = 4'd4;
    localparam logic [3:0] A_IDATA = 4'd5;
    localparam logic [3:0] A_STAT  = 4'd6;
    localparam logic [3:0] A_PERF  = 4'd7;
    localparam logic [3:0] A_DBG   = 4'd8;
    localparam logic [3:0] A_IRQEN = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FIN} state_t;
    state_t state, state_nx;

    logic [SEL_W-1:0]      sel;
    logic [SEL_W-1:0]      sel_wdata;
    logic [NUM_ENG-1:0]    sel_oh;
    logic [IMG_ADDR_W-1:0] img_ptr;
    logic [PERF_W-1:0]     perf;
    logic                  done, err, aborted;
    logic                  done_nx, err_nx;
    logic                  busy, cfg_ok, wr_ctrl;
    logic                  start_req, abort_req, clr_req;
    logic                  launch, blocked, done_hit, abort_hit;
    logic [7:0]            dbg_byte;
    logic                  irq_en_rd;
    logic [31:0]           rd_mux;

    assign busy      = (state != S_IDLE);
    assign cfg_ok    = avs_write & ~busy;
    assign wr_ctrl   = avs_write && (avs_address == A_CTRL);
    assign start_req = wr_ctrl & avs_writedata[0];
    assign abort_req = wr_ctrl & avs_writedata[1];
    assign clr_req   = wr_ctrl & avs_writedata[2];
    assign launch    = start_req & ~busy;
    // Any config write (SEL..IMG_DATA) or START during a run is dropped and flagged.
    assign blocked   = busy & (start_req |
                       (avs_write & (avs_address >= A_SEL) & (avs_address <= A_IDATA)));
    assign done_hit  = (state == S_RUN) & eng_done[sel] & ~abort_req;
    assign abort_hit = (state == S_RUN) & abort_req;

    assign sel_wdata = (avs_writedata >= 32'(NUM_ENG)) ? SEL_W'(NUM_ENG - 1)
                                                       : avs_writedata[SEL_W-1:0];
    assign dbg_byte  = eng_dbg[{sel, 3'b000} +: 8];

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (launch) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_RUN;
            S_RUN: begin
                if (abort_req)          state_nx = S_IDLE;
                else if (eng_done[sel]) state_nx = S_FIN;
            end
            S_FIN:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        eng_start = '0;
        if (state == S_LAUNCH) eng_start = sel_oh;
    end

    // Sets take priority over CLR so a completion landing on a CLR is never lost.
    always_comb begin
        done_nx = done;
        err_nx  = err;
        if (launch || clr_req) done_nx = 1'b0;
        if (done_hit)          done_nx = 1'b1;
        if (clr_req)           err_nx  = 1'b0;
        if (blocked)           err_nx  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel          <= '0;
            x_ratio      <= '0;
            y_ratio      <= '0;
            img_ptr      <= '0;
            perf         <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            aborted      <= 1'b0;
            eng_cfg_we   <= '0;
            eng_cfg_addr <= '0;
            eng_cfg_data <= '0;
        end else begin
            done       <= done_nx;
            err        <= err_nx;
            eng_cfg_we <= '0;
            if (cfg_ok) begin
                case (avs_address)
                    A_SEL:   sel     <= sel_wdata;
                    A_XRAT:  x_ratio <= avs_writedata[15:0];
                    A_YRAT:  y_ratio <= avs_writedata[15:0];
                    A_IADDR: img_ptr <= avs_writedata[IMG_ADDR_W-1:0];
                    A_IDATA: begin
                        eng_cfg_we   <= sel_oh;
                        eng_cfg_addr <= img_ptr;
                        eng_cfg_data <= avs_writedata[7:0];
                        img_ptr      <= img_ptr + IMG_ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
            if (launch) begin
                aborted <= 1'b0;
                perf    <= '0;
            end else begin
                if (abort_hit) aborted <= 1'b1;
                if (state == S_RUN && perf != '1) perf <= perf + PERF_W'(1);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_SEL:   rd_mux[SEL_W-1:0]      = sel;
            A_XRAT:  rd_mux[15:0]           = x_ratio;
            A_YRAT:  rd_mux[15:0]           = y_ratio;
            A_IADDR: rd_mux[IMG_ADDR_W-1:0] = img_ptr;
            A_STAT:  rd_mux[3:0]            = {aborted, err, done, busy};
            A_PERF:  rd_mux[PERF_W-1:0]     = perf;
            A_DBG:   rd_mux[7:0]            = dbg_byte;
            A_IRQEN: rd_mux[0]              = irq_en_rd;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) avs_readdata <= '0;
        else      avs_readdata <= avs_read ? rd_mux : '0;
    end

`ifdef DSC_CTRL_IRQ_EN
    logic irq_en, irq_en_nx;

    assign irq_en_nx = (avs_write && avs_address == A_IRQEN) ? avs_writedata[0] : irq_en;
    assign irq_en_rd = irq_en;

    // Built from next-state values so irq tracks DONE/ERR with the same latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= irq_en_nx;
            irq    <= irq_en_nx & (done_nx | err_nx);
        end
    end
`else
    assign irq_en_rd = 1'b0;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_dsc_ctrl_mm.sv
// tb_dsc_ctrl_mm: randomized self-checking bench for dsc_ctrl_mm against a
// transaction-level model of the register file, image loader and run sequencer.
`timescale 1ns/1ps
module tb_dsc_ctrl_mm;
    localparam int NUM_ENG    = 2;
    localparam int IMG_ADDR_W = 18;
    localparam int PERF_W     = 32;

    localparam logic [3:0] A_CTRL  = 4'd0;
    localparam logic [3:0] A_SEL   = 4'd1;
    localparam logic [3:0] A_XRAT  = 4'd2;
    localparam logic [3:0] A_YRAT  = 4'd3;
    localparam logic [3:0] A_IADDR = 4'd4;
    localparam logic [3:0] A_IDATA = 4'd5;
    localparam logic [3:0] A_STAT  = 4'd6;
    localparam logic [3:0] A_PERF  = 4'd7;
    localparam logic [3:0] A_DBG   = 4'd8;
    localparam logic [3:0] A_IRQEN = 4'd9;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  avs_read, avs_write;
    logic [3:0]            avs_address;
    logic [31:0]           avs_writedata, avs_readdata;
    logic [NUM_ENG-1:0]    eng_start, eng_cfg_we, eng_done;
    logic [IMG_ADDR_W-1:0] eng_cfg_addr;
    logic [7:0]            eng_cfg_data;
    logic [15:0]           x_ratio, y_ratio;
    logic [8*NUM_ENG-1:0]  eng_dbg;
    logic                  irq;

    dsc_ctrl_mm #(.NUM_ENG(NUM_ENG), .IMG_ADDR_W(IMG_ADDR_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst(rst),
        .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .eng_start(eng_start), .eng_cfg_we(eng_cfg_we), .eng_cfg_addr(eng_cfg_addr),
        .eng_cfg_data(eng_cfg_data), .x_ratio(x_ratio), .y_ratio(y_ratio),
        .eng_done(eng_done), .eng_dbg(eng_dbg), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes
    int start_cnt [NUM_ENG];
    int we_eng[$], we_addr[$], we_data[$], we_cyc[$];
    always @(negedge clk) begin
        for (int i = 0; i < NUM_ENG; i++) begin
            if (eng_start[i]) start_cnt[i] <= start_cnt[i] + 1;
            if (eng_cfg_we[i]) begin
                we_eng.push_back(i);
                we_addr.push_back(int'(eng_cfg_addr));
                we_data.push_back(int'(eng_cfg_data));
                we_cyc.push_back(cyc);
            end
        end
    end

    // Reference model
    int          m_sel, m_ptr;
    logic [15:0] m_x, m_y;
    bit          m_done, m_err, m_ab, m_irqen;
    int unsigned m_perf;

    function automatic logic exp_irq();
`ifdef DSC_CTRL_IRQ_EN
        return m_irqen & (m_done | m_err);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_sel = 0; m_ptr = 0; m_x = '0; m_y = '0;
        m_done = 0; m_err = 0; m_ab = 0; m_irqen = 0; m_perf = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        avs_read = 1'b1; avs_address = a;
        @(negedge clk);
        d = avs_readdata;
        avs_read = 1'b0;
    endtask

    task automatic set_sel(input int v);
        bus_wr(A_SEL, 32'(v));
        m_sel = (v >= NUM_ENG) ? NUM_ENG - 1 : v;
    endtask

    task automatic set_irqen(input bit v);
        bus_wr(A_IRQEN, {31'd0, v});
`ifdef DSC_CTRL_IRQ_EN
        m_irqen = v;
`endif
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] r;
        bus_rd(A_SEL, r);   chk({tag, ".sel"}, r, 32'(m_sel));
        bus_rd(A_XRAT, r);  chk({tag, ".xratio"}, r, {16'd0, m_x});
        bus_rd(A_YRAT, r);  chk({tag, ".yratio"}, r, {16'd0, m_y});
        bus_rd(A_IADDR, r); chk({tag, ".img_addr"}, r, 32'(m_ptr));
        bus_rd(A_STAT, r);  chk({tag, ".status"}, r, {28'd0, m_ab, m_err, m_done, 1'b0});
        bus_rd(A_PERF, r);  chk({tag, ".perf"}, r, m_perf);
        bus_rd(A_IRQEN, r); chk({tag, ".irq_en"}, r, {31'd0, m_irqen});
        bus_rd(A_CTRL, r);  chk({tag, ".ctrl_rd"}, r, 32'd0);
        bus_rd(4'hC, r);    chk({tag, ".unmapped"}, r, 32'd0);
        chk({tag, ".x_out"}, {16'd0, x_ratio}, {16'd0, m_x});
        chk({tag, ".y_out"}, {16'd0, y_ratio}, {16'd0, m_y});
        chk({tag, ".irq"}, {31'd0, irq}, {31'd0, exp_irq()});
    endtask

    // n back-to-back IMG_DATA writes; fixed data gives AA, BB, CC, ...
    task automatic img_load(input int n, input bit fixed);
        logic [7:0]  d[$];
        logic [31:0] r, t;
        int          mask;
        mask = (1 << IMG_ADDR_W) - 1;
        we_eng.delete(); we_addr.delete(); we_data.delete(); we_cyc.delete();
        for (int j = 0; j < n; j++) begin
            t = $urandom;
            d.push_back(fixed ? 8'(8'hAA + 8'h11 * j) : t[7:0]);
            bus_wr(A_IDATA, {24'd0, d[j]});
        end
        repeat (2) @(negedge clk);
        chk("img.count", 32'(we_eng.size()), 32'(n));
        for (int j = 0; j < n && j < we_eng.size(); j++) begin
            chk("img.eng", 32'(we_eng[j]), 32'(m_sel));
            chk("img.addr", 32'(we_addr[j]), 32'((m_ptr + j) & mask));
            chk("img.data", 32'(we_data[j]), {24'd0, d[j]});
            chk("img.gap", 32'(we_cyc[j] - we_cyc[0]), 32'(j));
        end
        m_ptr = (m_ptr + n) & mask;
        bus_rd(A_IADDR, r);
        chk("img.ptr", r, 32'(m_ptr));
    endtask

    // One run of d RUN cycles ending in done (or abort with done raised alongside).
    task automatic do_run(input int d, input bit abort_it, input bit poke, input bit clr_end);
        int                 sb [NUM_ENG];
        int                 nwe;
        logic [NUM_ENG-1:0] oh;
        logic [31:0]        r, t;
        oh = '0; oh[m_sel] = 1'b1;
        sb = start_cnt;
        nwe = we_eng.size();
        bus_wr(A_CTRL, 32'd1);
        m_done = 0; m_ab = 0;
        chk("run.start_pulse", 32'(eng_start), 32'(oh));
        for (int i = 0; i < d; i++) begin
            t = $urandom;
            eng_done = t[NUM_ENG-1:0] & ~oh;
            if (poke && i == 1) begin
                bus_wr(A_XRAT, 32'h0180); m_err = 1;
            end else if (poke && i == 2) begin
                bus_wr(A_CTRL, 32'd1); m_err = 1;
            end else if (poke && i == 3) begin
                bus_wr(A_IDATA, 32'h5A); m_err = 1;
            end else begin
                @(negedge clk);
            end
        end
        eng_done = oh;
        if (abort_it) begin
            bus_wr(A_CTRL, 32'd2);
            m_ab = 1;
        end else begin
            if (clr_end) begin
                bus_wr(A_CTRL, 32'd4);
                m_err = 0;
            end else begin
                @(negedge clk);
            end
            m_done = 1;
        end
        eng_done = '0;
        m_perf = d;
        for (int k = 0; k < 16; k++) begin
            bus_rd(A_STAT, r);
            if (r[0] == 1'b0) break;
        end
        chk("run.busy_clear", {31'd0, r[0]}, 32'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < NUM_ENG; i++)
            chk("run.start_count", 32'(start_cnt[i]), 32'(sb[i] + ((i == m_sel) ? 1 : 0)));
        chk("run.no_cfg_we", 32'(we_eng.size()), 32'(nwe));
        bus_rd(A_PERF, r);
        chk("run.perf", r, m_perf);
        if (abort_it) begin
            repeat (5) @(negedge clk);
            bus_rd(A_PERF, r);
            chk("run.perf_frozen", r, m_perf);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, t, t2;
        logic [15:0] dbgv;
        int          v;
        rst = 1'b1;
        avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
        eng_done = '0; eng_dbg = '0;
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst.eng_start", 32'(eng_start), 32'd0);
        chk("rst.cfg_we", 32'(eng_cfg_we), 32'd0);
        chk("rst.readdata", avs_readdata, 32'd0);
        chk("rst.irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_regs("reset");

        // Image load across the pointer wrap
        set_sel(1);
        bus_wr(A_IADDR, 32'h3FFFF); m_ptr = 'h3FFFF;
        img_load(3, 1'b1);

        // SEL clamp and debug byte mux
        set_sel(3);
        bus_rd(A_SEL, r); chk("sel.clamp", r, 32'(m_sel));
        t = $urandom; dbgv = t[15:0]; eng_dbg = dbgv;
        for (int s = 0; s < NUM_ENG; s++) begin
            set_sel(s);
            bus_rd(A_DBG, r);
            chk("dbg", r, 32'((dbgv >> (8 * s)) & 16'h00FF));
        end

        // Unmapped writes are ignored
        bus_wr(4'hB, 32'hFFFF_FFFF);
        bus_wr(4'hF, 32'hFFFF_FFFF);
        t = $urandom; bus_wr(A_XRAT, t); m_x = t[15:0];
        t = $urandom; bus_wr(A_YRAT, t); m_y = t[15:0];
        check_regs("cfg");

        // Normal run, abort, busy protection
        set_sel(0);
        do_run(10, 1'b0, 1'b0, 1'b0);
        check_regs("run10");
        do_run(7, 1'b1, 1'b0, 1'b0);
        check_regs("abort");
        do_run(12, 1'b0, 1'b1, 1'b0);
        check_regs("busy_prot");
        bus_wr(A_CTRL, 32'd4); m_err = 0; m_done = 0;
        check_regs("clr");

        // Interrupt holds until CLR
        set_irqen(1'b1);
        do_run(5, 1'b0, 1'b0, 1'b0);
        check_regs("irq_set");
        repeat (5) @(negedge clk);
        chk("irq.hold", {31'd0, irq}, {31'd0, exp_irq()});
        bus_wr(A_CTRL, 32'd4); m_err = 0; m_done = 0;
        chk("irq.clr", {31'd0, irq}, 32'd0);

        // CLR on the same edge as the done set: done survives, err clears
        do_run(6, 1'b0, 1'b1, 1'b1);
        check_regs("clr_vs_done");

        // Randomized sequences
        for (int it = 0; it < 10; it++) begin
            v = $urandom_range(0, 2);
            set_sel((v == 2) ? 3 : v);
            t = $urandom; bus_wr(A_XRAT, t); m_x = t[15:0];
            t = $urandom; bus_wr(A_YRAT, t); m_y = t[15:0];
            if ($urandom_range(0, 1) == 1) begin
                t2 = $urandom;
                bus_wr(A_IADDR, t2);
                m_ptr = int'(t2) & ((1 << IMG_ADDR_W) - 1);
                img_load($urandom_range(1, 6), 1'b0);
            end
            set_irqen(1'($urandom_range(0, 1)));
            do_run($urandom_range(4, 30), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_regs("rand");
            if ($urandom_range(0, 1) == 1) begin
                bus_wr(A_CTRL, 32'd4); m_err = 0; m_done = 0;
            end
        end

        // Asynchronous reset in the middle of a run
        bus_wr(A_XRAT, 32'h1234); m_x = 16'h1234;
        bus_wr(A_YRAT, 32'h5678); m_y = 16'h5678;
        bus_wr(A_CTRL, 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst.eng_start", 32'(eng_start), 32'd0);
        chk("arst.cfg_we", 32'(eng_cfg_we), 32'd0);
        chk("arst.cfg_addr", 32'(eng_cfg_addr), 32'd0);
        chk("arst.cfg_data", 32'(eng_cfg_data), 32'd0);
        chk("arst.x_out", {16'd0, x_ratio}, 32'd0);
        chk("arst.y_out", {16'd0, y_ratio}, 32'd0);
        chk("arst.irq", {31'd0, irq}, 32'd0);
        chk("arst.readdata", avs_readdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check_regs("post_arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
